csi2_pkt_handler_mt: RTL and testbench
======================================

Name: csi2_pkt_handler_mt

Overview:
Parametrised CSI-2 packet handler sitting after lane merging/header ECC and before pixel unpacking. It parses one packet per header beat on a DATA_BYTES-wide AXI4-Stream and filters long packets by virtual channel and a data-type accept mask. It forwards only payload bytes, masking and stripping the 2-byte CRC, and adds tlast, tkeep and a start-of-frame tuser. It decodes short packets into frame/line strobes and a frame number, and flags truncated packets.

Parameters:
DATA_BYTES, 4, bytes per beat; legal 4 or 8
VC_FILTER_EN, 1, 1 = drop long packets whose VC != VC_ID; 0 = accept any VC
VC_ID, 0, accepted virtual channel (2 bits)
DT_ACCEPT, 64'h0000_0800_0000_0000, bit n set = long packet with DT n is forwarded (default RAW10 0x2B)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
pkt_i_tvalid  in  1  input stream valid
pkt_i_tready  out  1  input stream ready
pkt_i_tdata  in  8*DATA_BYTES  header or payload beat
pkt_i_tkeep  in  DATA_BYTES  byte valid; contiguous from LSB
pkt_i_tlast  in  1  upstream end of packet
pkt_o_tvalid  out  1  output valid
pkt_o_tready  in  1  output ready
pkt_o_tdata  out  8*DATA_BYTES  payload beat
pkt_o_tkeep  out  DATA_BYTES  payload byte valid (CRC bytes cleared)
pkt_o_tlast  out  1  last payload beat of packet
pkt_o_tuser  out  1  first beat of first forwarded packet after frame start
pkt_o_tdest  out  8  {VC[1:0], DT[5:0]} of the current packet
frame_start_o  out  1  1-cycle pulse on FS (DT 0x00)
frame_end_o  out  1  1-cycle pulse on FE (DT 0x01)
line_start_o  out  1  1-cycle pulse on LS (DT 0x02)
line_end_o  out  1  1-cycle pulse on LE (DT 0x03)
frame_num_o  out  16  WC field of the last FS
err_trunc_o  out  1  1-cycle pulse: input tlast before WC+2 bytes consumed

Behaviour:
- Reset: all outputs 0, state IDLE_S, counters 0.
- Header beat: byte0 = {VC[7:6], DT[5:0]}; bytes1-2 = WC little-endian; byte3 = ECC, ignored. Bytes above 3 on header beat ignored.
- pkt_i_tready = !pkt_o_tvalid || pkt_o_tready (single output register, full throughput). Accept = tvalid && tready.
- Output register loads only on accept. pkt_o_* hold stable while tvalid && !tready. Latency input→output 1 cycle.
- States:
  - IDLE_S: accept decodes header.
    - DT < 0x10 (short packet): pulse the matching strobe on the next cycle. FS also loads frame_num_o <= WC and arms sof_pend. Stay in IDLE_S.
    - DT >= 0x10, passes VC filter and DT_ACCEPT[DT]: latch wc <= WC, tdest, byte_cnt <= 0 -> RUN_S.
    - Any other long packet: latch wc -> DROP_S.
  - RUN_S:
    - Per accepted beat, n = popcount(tkeep). Payload mask bit i = tkeep[i] && (byte_cnt + i < wc). byte_cnt += n (17-bit, no wrap).
    - If mask != 0: emit beat with pkt_o_tkeep = mask and tuser = sof_pend (clear sof_pend once emitted).
    - pkt_o_tlast = 1 on the beat where byte_cnt + n >= wc, or on a truncated beat carrying payload.
    - A beat with mask == 0 (CRC-only) is consumed and not emitted.
    - Exit to IDLE_S when byte_cnt + n >= wc + 2 or on input tlast.
  - DROP_S: same counting, nothing emitted. Exits under the same conditions as RUN_S.
- Truncation: pkt_i_tlast accepted in RUN_S/DROP_S with byte_cnt + n < wc + 2 -> err_trunc_o pulse, state -> IDLE_S.
- Input tlast in IDLE_S is ignored. Missing tlast at the counted end is not an error.
- wc = 0 long packet: no output beats; the CRC beat is consumed, then IDLE_S.
- FE while sof_pend is still armed clears sof_pend.
- Reset asserted mid-packet: immediate return to IDLE_S, output valid dropped. The next beat after reset release is treated as a header.

Test Plan:
- DATA_BYTES=4, FS WC=7 -> frame_start_o one pulse, frame_num_o=7; then RAW10 VC0 WC=8 + 3 payload beats (last beat 2 CRC bytes padded) -> 2 output beats, tkeep 4'hF/4'hF, tlast on beat 2, tuser on beat 1, tdest=8'h2B.
- DATA_BYTES=4, RAW10 WC=6 -> beat2 tkeep=4'h3 with tlast; CRC bytes 2-3 masked; no third beat.
- DATA_BYTES=8, WC=13 -> beat1 tkeep=8'hFF, beat2 tkeep=8'h1F with tlast; CRC bytes 5-6 cleared.
- VC_ID=0, packet VC=1 DT 0x2B WC=8 -> no output beats, no error, next header parsed correctly; repeat with DT 0x2C (mask bit clear) -> dropped.
- RAW10 WC=16 with input tlast on payload beat 2 -> beat 2 emitted with tlast, err_trunc_o pulse, state IDLE_S.
- pkt_o_tready held low 5 cycles mid-packet -> pkt_i_tready low, output data stable, no bytes lost or duplicated; rst_n_i low mid-packet -> all outputs 0, next header accepted.

Source files
------------

// File: rtl/csi2_pkt_handler_mt.sv
// csi2_pkt_handler_mt
// CSI-2 packet handler between lane merge/header ECC and pixel unpacking.
// One header beat starts every packet. Short packets (DT < 0x10) turn into
// frame/line strobes. Long packets are filtered by VC and a DT accept mask.
// Accepted long packets have their payload forwarded with the CRC bytes
// stripped, plus tlast/tkeep and a start-of-frame tuser.
//
// Ports:
//   clk_i, rst_n_i       clock, async active-low reset
//   pkt_i_*              input AXI4-Stream (header or payload beats)
//   pkt_o_*              output AXI4-Stream (payload only), tdest={VC,DT}
//   frame_/line_*_o      1-cycle strobes for FS/FE/LS/LE short packets
//   frame_num_o          WC field of the most recent FS
//   err_trunc_o          1-cycle pulse when input tlast cuts a packet short
module csi2_pkt_handler_mt #(
  parameter int          DATA_BYTES   = 4,
  parameter bit          VC_FILTER_EN = 1'b1,
  parameter logic [1:0]  VC_ID        = 2'd0,
  parameter logic [63:0] DT_ACCEPT    = 64'h0000_0800_0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    pkt_i_tvalid,
  output logic                    pkt_i_tready,
  input  logic [8*DATA_BYTES-1:0] pkt_i_tdata,
  input  logic [DATA_BYTES-1:0]   pkt_i_tkeep,
  input  logic                    pkt_i_tlast,
  output logic                    pkt_o_tvalid,
  input  logic                    pkt_o_tready,
  output logic [8*DATA_BYTES-1:0] pkt_o_tdata,
  output logic [DATA_BYTES-1:0]   pkt_o_tkeep,
  output logic                    pkt_o_tlast,
  output logic                    pkt_o_tuser,
  output logic [7:0]              pkt_o_tdest,
  output logic                    frame_start_o,
  output logic                    frame_end_o,
  output logic                    line_start_o,
  output logic                    line_end_o,
  output logic [15:0]             frame_num_o,
  output logic                    err_trunc_o
);

  typedef enum logic [1:0] {IDLE_S, RUN_S, DROP_S} state_e;

  state_e                  state_q, state_d;
  logic [15:0]             wc_q, wc_d;
  logic [16:0]             cnt_q, cnt_d;
  logic [7:0]              tdest_q, tdest_d;
  logic                    sof_q, sof_d;
  logic [15:0]             fnum_q, fnum_d;
  logic                    fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic                    err_q, err_d;
  logic                    ovld_q, ovld_d;
  logic [8*DATA_BYTES-1:0] odata_q, odata_d;
  logic [DATA_BYTES-1:0]   okeep_q, okeep_d;
  logic                    olast_q, olast_d;
  logic                    ouser_q, ouser_d;

  logic                    accept;
  logic [1:0]              hdr_vc;
  logic [5:0]              hdr_dt;
  logic [15:0]             hdr_wc;
  logic                    hdr_pass;
  logic [3:0]              nbytes;
  logic [17:0]             cnt_nx;
  logic [17:0]             wc_ext;
  logic                    end_pay;
  logic                    done;
  logic                    trunc;
  logic [DATA_BYTES-1:0]   mask;
  logic [8*DATA_BYTES-1:0] mdata;

  // Single output register: it can take a new beat whenever it is empty or
  // draining this cycle, so throughput is one beat per clock.
  assign pkt_i_tready = !ovld_q || pkt_o_tready;
  assign accept       = pkt_i_tvalid && pkt_i_tready;

  assign hdr_vc   = pkt_i_tdata[7:6];
  assign hdr_dt   = pkt_i_tdata[5:0];
  assign hdr_wc   = pkt_i_tdata[23:8];
  assign hdr_pass = (!VC_FILTER_EN || (hdr_vc == VC_ID)) && DT_ACCEPT[hdr_dt];

  // Byte accounting is done 18 bits wide so that wc+2 and cnt+n never wrap.
  always_comb begin
    nbytes = '0;
    mask   = '0;
    mdata  = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      nbytes  = nbytes + 4'(pkt_i_tkeep[i]);
      mask[i] = pkt_i_tkeep[i] && (({1'b0, cnt_q} + 18'(i)) < wc_ext);
      mdata[8*i +: 8] = mask[i] ? pkt_i_tdata[8*i +: 8] : 8'h00;
    end
  end

  assign wc_ext  = {2'b00, wc_q};
  assign cnt_nx  = {1'b0, cnt_q} + 18'(nbytes);
  assign end_pay = cnt_nx >= wc_ext;
  assign done    = cnt_nx >= (wc_ext + 18'd2);
  assign trunc   = pkt_i_tlast && !done;

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    cnt_d   = cnt_q;
    tdest_d = tdest_q;
    sof_d   = sof_q;
    fnum_d  = fnum_q;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    ls_d    = 1'b0;
    le_d    = 1'b0;
    err_d   = 1'b0;
    // Valid falls once the held beat is taken; a new load overrides below.
    ovld_d  = ovld_q && !pkt_o_tready;
    odata_d = odata_q;
    okeep_d = okeep_q;
    olast_d = olast_q;
    ouser_d = ouser_q;

    if (accept) begin
      unique case (state_q)
        IDLE_S: begin
          if (hdr_dt[5:4] == 2'b00) begin
            fs_d = (hdr_dt == 6'h00);
            fe_d = (hdr_dt == 6'h01);
            ls_d = (hdr_dt == 6'h02);
            le_d = (hdr_dt == 6'h03);
            if (hdr_dt == 6'h00) begin
              fnum_d = hdr_wc;
              sof_d  = 1'b1;
            end
            // A frame that ends before any payload went out must not leak
            // its tuser into the next frame.
            if (hdr_dt == 6'h01) sof_d = 1'b0;
          end else begin
            wc_d  = hdr_wc;
            cnt_d = '0;
            if (hdr_pass) begin
              tdest_d = {hdr_vc, hdr_dt};
              state_d = RUN_S;
            end else begin
              state_d = DROP_S;
            end
          end
        end
        RUN_S, DROP_S: begin
          cnt_d = cnt_nx[16:0];
          if (state_q == RUN_S && mask != '0) begin
            ovld_d  = 1'b1;
            odata_d = mdata;
            okeep_d = mask;
            olast_d = end_pay || trunc;
            ouser_d = sof_q;
            sof_d   = 1'b0;
          end
          if (done || pkt_i_tlast) state_d = IDLE_S;
          err_d = trunc;
        end
        default: state_d = IDLE_S;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE_S;
      wc_q    <= '0;
      cnt_q   <= '0;
      tdest_q <= '0;
      sof_q   <= 1'b0;
      fnum_q  <= '0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      ls_q    <= 1'b0;
      le_q    <= 1'b0;
      err_q   <= 1'b0;
      ovld_q  <= 1'b0;
      odata_q <= '0;
      okeep_q <= '0;
      olast_q <= 1'b0;
      ouser_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      cnt_q   <= cnt_d;
      tdest_q <= tdest_d;
      sof_q   <= sof_d;
      fnum_q  <= fnum_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      ls_q    <= ls_d;
      le_q    <= le_d;
      err_q   <= err_d;
      ovld_q  <= ovld_d;
      odata_q <= odata_d;
      okeep_q <= okeep_d;
      olast_q <= olast_d;
      ouser_q <= ouser_d;
    end
  end

  assign pkt_o_tvalid  = ovld_q;
  assign pkt_o_tdata   = odata_q;
  assign pkt_o_tkeep   = okeep_q;
  assign pkt_o_tlast   = olast_q;
  assign pkt_o_tuser   = ouser_q;
  assign pkt_o_tdest   = tdest_q;
  assign frame_start_o = fs_q;
  assign frame_end_o   = fe_q;
  assign line_start_o  = ls_q;
  assign line_end_o    = le_q;
  assign frame_num_o   = fnum_q;
  assign err_trunc_o   = err_q;

endmodule

// File: tb/tb_csi2_pkt_handler_mt.sv
module tb_csi2_pkt_handler_mt;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 4-byte instance
  logic        i4_v, i4_r, i4_l, o4_v, o4_r, o4_l, o4_u;
  logic [31:0] i4_d, o4_d;
  logic [3:0]  i4_k, o4_k;
  logic [7:0]  o4_dest;
  logic        fs4, fe4, ls4, le4, err4;
  logic [15:0] fn4;
  // 8-byte instance
  logic        i8_v, i8_r, i8_l, o8_v, o8_r, o8_l, o8_u;
  logic [63:0] i8_d, o8_d;
  logic [7:0]  i8_k, o8_k;
  logic [7:0]  o8_dest;
  logic        fs8, fe8, ls8, le8, err8;
  logic [15:0] fn8;

  csi2_pkt_handler_mt #(.DATA_BYTES(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n),
    .pkt_i_tvalid(i4_v), .pkt_i_tready(i4_r), .pkt_i_tdata(i4_d),
    .pkt_i_tkeep(i4_k), .pkt_i_tlast(i4_l),
    .pkt_o_tvalid(o4_v), .pkt_o_tready(o4_r), .pkt_o_tdata(o4_d),
    .pkt_o_tkeep(o4_k), .pkt_o_tlast(o4_l), .pkt_o_tuser(o4_u),
    .pkt_o_tdest(o4_dest),
    .frame_start_o(fs4), .frame_end_o(fe4), .line_start_o(ls4),
    .line_end_o(le4), .frame_num_o(fn4), .err_trunc_o(err4));

  csi2_pkt_handler_mt #(.DATA_BYTES(8)) u_dut8 (
    .clk_i(clk), .rst_n_i(rst_n),
    .pkt_i_tvalid(i8_v), .pkt_i_tready(i8_r), .pkt_i_tdata(i8_d),
    .pkt_i_tkeep(i8_k), .pkt_i_tlast(i8_l),
    .pkt_o_tvalid(o8_v), .pkt_o_tready(o8_r), .pkt_o_tdata(o8_d),
    .pkt_o_tkeep(o8_k), .pkt_o_tlast(o8_l), .pkt_o_tuser(o8_u),
    .pkt_o_tdest(o8_dest),
    .frame_start_o(fs8), .frame_end_o(fe8), .line_start_o(ls8),
    .line_end_o(le8), .frame_num_o(fn8), .err_trunc_o(err8));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    logic [7:0]  dest;
  } exp_t;
  exp_t q4[$];
  exp_t q8[$];

  // Input beat plus what the 4-byte instance must do with it.
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        emit;
    logic [3:0]  ek;
    logic        el;
    logic        eu;
    logic [4:0]  estb;   // {err, le, ls, fe, fs}
    logic [15:0] fn;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input bit w8, input logic [63:0] d, input logic [7:0] k,
                      input logic l, input logic u);
    exp_t e;
    e.d = '0;
    for (int i = 0; i < 8; i++) if (k[i]) e.d[8*i +: 8] = d[8*i +: 8];
    e.k = k; e.l = l; e.u = u; e.dest = 8'h2B;
    if (w8) q8.push_back(e); else q4.push_back(e);
  endtask

  // Present one beat and hold it until the DUT accepts it.
  task automatic send(input bit w8, input logic [63:0] d, input logic [7:0] k, input logic l);
    int t;
    if (w8) begin i8_v = 1'b1; i8_d = d; i8_k = k; i8_l = l; end
    else begin i4_v = 1'b1; i4_d = d[31:0]; i4_k = k[3:0]; i4_l = l; end
    t = 0;
    forever begin
      @(negedge clk);
      if (w8 ? i8_r : i4_r) break;
      t++;
      if (t > 50) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: tready stuck low for %0d cycles, expected high", t);
        break;
      end
    end
    @(posedge clk); #1;
    if (w8) i8_v = 1'b0; else i4_v = 1'b0;
  endtask

  function automatic vec_t mk(logic [31:0] d, logic [3:0] k, logic l, logic emit,
                              logic [3:0] ek, logic el, logic eu, logic [4:0] estb,
                              logic [15:0] fn);
    vec_t v;
    v.d = d; v.k = k; v.l = l; v.emit = emit; v.ek = ek; v.el = el; v.eu = eu;
    v.estb = estb; v.fn = fn;
    return v;
  endfunction

  // Scoreboard monitors: a transfer happens at the next posedge when both
  // valid and ready are high at the negedge.
  always @(negedge clk) begin
    if (rst_n && o4_v && o4_r) begin
      if (q4.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL o4_unexpected: got beat %h keep %h, expected none", o4_d, o4_k);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("o4_tdata", {32'h0, o4_d}, e.d);
        chk("o4_tkeep", {60'h0, o4_k}, {56'h0, e.k});
        chk("o4_tlast", {63'h0, o4_l}, {63'h0, e.l});
        chk("o4_tuser", {63'h0, o4_u}, {63'h0, e.u});
        chk("o4_tdest", {56'h0, o4_dest}, {56'h0, e.dest});
      end
    end
    if (rst_n && o8_v && o8_r) begin
      if (q8.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL o8_unexpected: got beat %h keep %h, expected none", o8_d, o8_k);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("o8_tdata", o8_d, e.d);
        chk("o8_tkeep", {56'h0, o8_k}, {56'h0, e.k});
        chk("o8_tlast", {63'h0, o8_l}, {63'h0, e.l});
        chk("o8_tuser", {63'h0, o8_u}, {63'h0, e.u});
        chk("o8_tdest", {56'h0, o8_dest}, {56'h0, e.dest});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_zero4(input string nm);
    chk({nm, "_tvalid"}, {63'h0, o4_v}, 64'h0);
    chk({nm, "_tdata"}, {32'h0, o4_d}, 64'h0);
    chk({nm, "_tkeep"}, {60'h0, o4_k}, 64'h0);
    chk({nm, "_tlast_tuser"}, {62'h0, o4_l, o4_u}, 64'h0);
    chk({nm, "_tdest"}, {56'h0, o4_dest}, 64'h0);
    chk({nm, "_strobes"}, {59'h0, err4, le4, ls4, fe4, fs4}, 64'h0);
    chk({nm, "_frame_num"}, {48'h0, fn4}, 64'h0);
    chk({nm, "_tready"}, {63'h0, i4_r}, 64'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    i4_v = 0; i4_d = '0; i4_k = '0; i4_l = 0; o4_r = 1'b1;
    i8_v = 0; i8_d = '0; i8_k = '0; i8_l = 0; o8_r = 1'b1;

    //        data           keep  l  emit ekeep el eu estb      fn
    tbl.push_back(mk(32'h0000_0700, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00001, 16'h0007)); // FS wc=7
    tbl.push_back(mk(32'h0000_082B, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007)); // RAW10 wc=8
    tbl.push_back(mk(32'h4433_2211, 4'hF, 0, 1, 4'hF, 0, 1, 5'b00000, 16'h0007));
    tbl.push_back(mk(32'h8877_6655, 4'hF, 0, 1, 4'hF, 1, 0, 5'b00000, 16'h0007));
    tbl.push_back(mk(32'h0000_ABCD, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007)); // CRC+pad
    tbl.push_back(mk(32'h0000_062B, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007)); // RAW10 wc=6
    tbl.push_back(mk(32'hA3A2_A1A0, 4'hF, 0, 1, 4'hF, 0, 0, 5'b00000, 16'h0007));
    tbl.push_back(mk(32'hEEEE_B1B0, 4'hF, 0, 1, 4'h3, 1, 0, 5'b00000, 16'h0007)); // 2 pay + CRC
    tbl.push_back(mk(32'h0000_086B, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007)); // VC1: drop
    tbl.push_back(mk(32'h1111_1111, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007));
    tbl.push_back(mk(32'h1212_1212, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007));
    tbl.push_back(mk(32'h1313_1313, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007));
    tbl.push_back(mk(32'h0000_042C, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007)); // DT 2C: drop
    tbl.push_back(mk(32'h2222_2222, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007));
    tbl.push_back(mk(32'h0000_3333, 4'h3, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007));
    tbl.push_back(mk(32'h0000_0002, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00100, 16'h0007)); // LS
    tbl.push_back(mk(32'h0000_0003, 4'hF, 0, 0, 4'h0, 0, 0, 5'b01000, 16'h0007)); // LE
    tbl.push_back(mk(32'h0000_102B, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007)); // wc=16
    tbl.push_back(mk(32'h5555_5555, 4'hF, 0, 1, 4'hF, 0, 0, 5'b00000, 16'h0007));
    tbl.push_back(mk(32'h6666_6666, 4'hF, 1, 1, 4'hF, 1, 0, 5'b10000, 16'h0007)); // truncated
    tbl.push_back(mk(32'h0000_0001, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00010, 16'h0007)); // FE
    tbl.push_back(mk(32'h0000_002B, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007)); // wc=0
    tbl.push_back(mk(32'h0000_7777, 4'h3, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h0007)); // CRC only
    tbl.push_back(mk(32'h0012_3400, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00001, 16'h1234)); // FS
    tbl.push_back(mk(32'h0000_0001, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00010, 16'h1234)); // FE clears sof
    tbl.push_back(mk(32'h0000_042B, 4'hF, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h1234));
    tbl.push_back(mk(32'h9999_9999, 4'hF, 0, 1, 4'hF, 1, 0, 5'b00000, 16'h1234));
    tbl.push_back(mk(32'h0000_8888, 4'h3, 0, 0, 4'h0, 0, 0, 5'b00000, 16'h1234));

    repeat (3) @(posedge clk);
    #1;
    chk_zero4("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].emit) push(0, {32'h0, tbl[i].d}, {4'h0, tbl[i].ek}, tbl[i].el, tbl[i].eu);
      send(0, {32'h0, tbl[i].d}, {4'h0, tbl[i].k}, tbl[i].l);
      chk($sformatf("row%0d_strobes", i), {59'h0, err4, le4, ls4, fe4, fs4}, {59'h0, tbl[i].estb});
      chk($sformatf("row%0d_frame_num", i), {48'h0, fn4}, {48'h0, tbl[i].fn});
    end

    // Backpressure: output stalls 5 cycles with a beat held.
    send(0, 64'h0000_0C2B, 8'hF, 0);
    push(0, 64'hC3C2_C1C0, 8'hF, 0, 0);
    push(0, 64'hD3D2_D1D0, 8'hF, 0, 0);
    push(0, 64'hE3E2_E1E0, 8'hF, 1, 0);
    send(0, 64'hC3C2_C1C0, 8'hF, 0);
    o4_r = 1'b0;
    i4_v = 1'b1; i4_d = 32'hD3D2_D1D0; i4_k = 4'hF; i4_l = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_tready", c), {63'h0, i4_r}, 64'h0);
      chk($sformatf("stall%0d_tdata", c), {31'h0, o4_v, o4_d}, {31'h0, 1'b1, 32'hC3C2_C1C0});
    end
    @(posedge clk); #1;
    o4_r = 1'b1;
    send(0, 64'hD3D2_D1D0, 8'hF, 0);
    send(0, 64'hE3E2_E1E0, 8'hF, 0);
    send(0, 64'h0000_F0F0, 8'h3, 0);

    // Reset mid-packet, then the next beat must be parsed as a header.
    send(0, 64'h0000_102B, 8'hF, 0);
    push(0, 64'h2726_2524, 8'hF, 0, 0);
    send(0, 64'h2726_2524, 8'hF, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero4("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 64'h0000_042B, 8'hF, 0);
    push(0, 64'h3736_3534, 8'hF, 1, 0);
    send(0, 64'h3736_3534, 8'hF, 0);
    chk("after_reset_err", {63'h0, err4}, 64'h0);
    send(0, 64'h0000_5A5A, 8'h3, 0);

    // 8-byte lanes: FS then RAW10 wc=13.
    send(1, 64'h0, 8'hFF, 0);
    chk("w8_fs", {59'h0, err8, le8, ls8, fe8, fs8}, 64'h1);
    send(1, 64'h0000_0000_0000_0D2B, 8'hFF, 0);
    push(1, 64'h0807_0605_0403_0201, 8'hFF, 0, 1);
    push(1, 64'h1817_1615_1413_1211, 8'h1F, 1, 0);
    send(1, 64'h0807_0605_0403_0201, 8'hFF, 0);
    send(1, 64'h1817_1615_1413_1211, 8'hFF, 0);
    chk("w8_err", {63'h0, err8}, 64'h0);

    repeat (5) @(posedge clk);
    #1;
    chk("q4_drained", 64'(q4.size()), 64'h0);
    chk("q8_drained", 64'(q8.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
